io_mem_intr: RTL and testbench
==============================

Name: io_mem_intr

Overview:
- Memory-mapped IO block downstream of the CPU's io_cs/io_rd/io_wr port. It consumes the ALU address and store data the CPU produces, and returns load data on the CPU's data-in bus.
- Contains a byte-addressable big-endian IO memory, a status/timer register pair and an interrupt source.
- The interrupt source drives the CPU intr input and takes int_ack back.
- Interrupt sources are an external asynchronous event pin and a programmable countdown timer.

Parameters:
- DEPTH, 1024, IO memory size in bytes (power of two, >= 16).
- STAT_ADDR, 32'h000003F8, word address of the INT_STATUS register.
- TMR_ADDR, 32'h000003FC, word address of the TIMER_RELOAD register.

Ports:
- sys_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_cs  in  1  chip select.
- io_rd  in  1  read strobe.
- io_wr  in  1  write strobe.
- io_addr  in  32  byte address; CPU ALU output.
- io_din  in  32  store data; CPU D_OUT.
- io_dout  out  32  load data to the CPU.
- ext_evt  in  1  asynchronous external event.
- int_ack  in  1  CPU interrupt acknowledge, one-cycle pulse.
- intr  out  1  interrupt request to the CPU.

Behaviour:
- Clock and reset: one clock (sys_clk); reset is asynchronous, active-high.
- Reset values:
  - intr=0; pending bits=0; lost=0; ack_seen=0.
  - reload=0; count=0; synchronizer flops=0.
  - Memory contents are not reset.
  - io_dout=0 while reset is held.
- Address decode:
  - Effective address = {io_addr[31:2],2'b00}; io_addr[1:0] is ignored.
  - Register hit when the effective address equals STAT_ADDR or TMR_ADDR.
  - Otherwise memory at index (effective address mod DEPTH), so addresses wrap.
- Memory word format: big-endian, byte[a]=bits 31:24 through byte[a+3]=bits 7:0.
- Reads:
  - Combinational, zero latency.
  - io_dout = selected word when io_cs&io_rd, else 32'h0.
- Writes: take effect on the rising edge when io_cs&io_wr.
- Simultaneous read and write: io_dout shows pre-write data that cycle.
- INT_STATUS read value: {29'b0, lost, tmr_pend, ext_pend}.
- INT_STATUS write: write-1-to-clear on bits 2:0; other bits ignored.
- TIMER_RELOAD read value: reload.
- TIMER_RELOAD write:
  - reload <= io_din and count <= io_din.
  - A write of 0 disables the timer.
- External event path:
  - ext_evt passes through a 2-flop synchronizer, then a rising-edge detector.
  - evt_edge asserts 3 cycles after ext_evt rises, assuming setup is met.
- Timer:
  - When reload!=0 the timer decrements count every cycle.
  - When count==1, next cycle count <= reload and tmr_evt pulses for one cycle.
  - A TIMER_RELOAD write in the same cycle overrides the decrement and reload.
- Pending flags:
  - evt_edge sets ext_pend; tmr_evt sets tmr_pend.
  - If an event arrives while its bit is already 1, lost is set.
  - Set has priority over a W1C clear in the same cycle.
- Interrupt handshake:
  - intr = (ext_pend|tmr_pend) & ~ack_seen, driven from registers (no combinational path from inputs).
  - int_ack while intr=1: ack_seen <= 1, so intr drops the next cycle.
  - ack_seen clears when both pending bits are 0 (ISR has written status).
  - A new event after that re-raises intr.
  - int_ack while intr=0 is ignored.
  - An event arriving while ack_seen=1 sets its pending bit but does not raise intr until ack_seen clears. After ack_seen clears, intr re-raises only if a pending bit is set.
- Reset mid-handshake: all interrupt state clears; intr=0 on the same edge (asynchronous).

Test Plan:
- Memory write/read: write 32'hDEADBEEF at 0x10, then read 0x10 → io_dout=DEADBEEF. Read 0x12 → DEADBEEF (low bits ignored). Read 0x10+DEPTH → DEADBEEF (wrap).
- External interrupt:
  - Pulse ext_evt → intr=1 exactly 4 cycles later (3 cycles to evt_edge, +1 to register).
  - int_ack → intr=0 the next cycle.
  - Read STAT → 0x1.
  - Write STAT 0x1 → STAT=0, ack_seen=0, intr stays 0.
- Timer:
  - Write TMR=5 → tmr_pend=1 after 5 cycles, then every 5 cycles.
  - Two expiries without a clear → STAT=0x6.
  - Write TMR=0 → no further events.
- Simultaneous set and clear: write STAT 0x1 in the same cycle evt_edge fires → ext_pend stays 1 and lost stays 0.
- Ack while idle, then reset:
  - int_ack with intr=0 → no state change.
  - Assert reset asynchronously while intr=1 → intr=0 before the next clock edge; STAT=0 and TMR=0 after release.

Source files
------------

// File: rtl/io_mem_intr.sv
// io_mem_intr: memory-mapped IO block for the CPU's io_cs/io_rd/io_wr port.
// It holds a big-endian byte memory, an INT_STATUS / TIMER_RELOAD register
// pair, and an interrupt source fed by an external event pin and a
// countdown timer.
module io_mem_intr #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] STAT_ADDR = 32'h0000_03F8,
    parameter logic [31:0] TMR_ADDR  = 32'h0000_03FC
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    input  logic        ext_evt,
    input  logic        int_ack,
    output logic        intr
);

    localparam int AW = $clog2(DEPTH);

    // Address decode: word aligned, memory index wraps modulo DEPTH.
    logic [31:0]   eff_addr;
    logic [AW-1:0] mem_idx;
    logic          stat_hit, tmr_hit;
    logic          rd_en, wr_en, mem_wr, stat_wr, tmr_wr;
    logic          unused_addr_bits;

    assign eff_addr         = {io_addr[31:2], 2'b00};
    assign mem_idx          = eff_addr[AW-1:0];
    assign stat_hit         = (eff_addr == STAT_ADDR);
    assign tmr_hit          = (eff_addr == TMR_ADDR);
    assign rd_en            = io_cs & io_rd;
    assign wr_en            = io_cs & io_wr;
    assign mem_wr           = wr_en & ~stat_hit & ~tmr_hit;
    assign stat_wr          = wr_en & stat_hit;
    assign tmr_wr           = wr_en & tmr_hit;
    assign unused_addr_bits = ^io_addr[1:0];

    // Byte memory, most significant byte at the lowest address.
    logic [7:0]  mem [DEPTH];
    logic [31:0] mem_word;

    // Word store into four consecutive bytes.
    // NOTE: the memory array has no reset so it maps onto RAM; software must initialise it.
    always_ff @(posedge sys_clk) begin
        if (mem_wr) begin
            mem[{mem_idx[AW-1:2], 2'b00}] <= io_din[31:24];
            mem[{mem_idx[AW-1:2], 2'b01}] <= io_din[23:16];
            mem[{mem_idx[AW-1:2], 2'b10}] <= io_din[15:8];
            mem[{mem_idx[AW-1:2], 2'b11}] <= io_din[7:0];
        end
    end

    assign mem_word = {mem[{mem_idx[AW-1:2], 2'b00}], mem[{mem_idx[AW-1:2], 2'b01}],
                       mem[{mem_idx[AW-1:2], 2'b10}], mem[{mem_idx[AW-1:2], 2'b11}]};

    // Interrupt and timer state.
    logic        sync1, sync2, sync3, evt_edge;
    logic [31:0] reload, count;
    logic        tmr_evt;
    logic        ext_pend, tmr_pend, lost, ack_seen;
    logic        ext_pend_n, tmr_pend_n, lost_n, ack_seen_n;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            evt_edge <= 1'b0;
        end else begin
            sync1    <= ext_evt;
            sync2    <= sync1;
            sync3    <= sync2;
            evt_edge <= sync2 & ~sync3;
        end
    end

    // Expiry is flagged while count sits at 1; a reload write cancels it.
    assign tmr_evt = (reload != 32'd0) && (count == 32'd1) && !tmr_wr;

    // Countdown timer; a TIMER_RELOAD write overrides decrement and reload.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            reload <= 32'd0;
            count  <= 32'd0;
        end else if (tmr_wr) begin
            reload <= io_din;
            count  <= io_din;
        end else if (reload != 32'd0) begin
            if (count == 32'd1) count <= reload;
            else                count <= count - 32'd1;
        end
    end

    // Next pending/lost/ack state: event set beats a W1C clear.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ext_pend_n = ext_pend;
        tmr_pend_n = tmr_pend;
        lost_n     = lost;
        if (evt_edge)                   ext_pend_n = 1'b1;
        else if (stat_wr && io_din[0])  ext_pend_n = 1'b0;
        if (tmr_evt)                    tmr_pend_n = 1'b1;
        else if (stat_wr && io_din[1])  tmr_pend_n = 1'b0;
        if ((evt_edge && ext_pend) || (tmr_evt && tmr_pend)) lost_n = 1'b1;
        else if (stat_wr && io_din[2])  lost_n = 1'b0;
        ack_seen_n = ack_seen | (int_ack & intr);
        if (!ext_pend_n && !tmr_pend_n) ack_seen_n = 1'b0;
    end

    // Interrupt state registers.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            tmr_pend <= 1'b0;
            lost     <= 1'b0;
            ack_seen <= 1'b0;
        end else begin
            ext_pend <= ext_pend_n;
            tmr_pend <= tmr_pend_n;
            lost     <= lost_n;
            ack_seen <= ack_seen_n;
        end
    end

    assign intr = (ext_pend | tmr_pend) & ~ack_seen;

    // Zero-latency read mux; idle bus and reset read as zero.
    always_comb begin
        io_dout = 32'h0;
        if (rd_en && !reset) begin
            if (stat_hit)     io_dout = {29'b0, lost, tmr_pend, ext_pend};
            else if (tmr_hit) io_dout = reload;
            else              io_dout = mem_word;
        end
    end

endmodule

// File: tb/tb_io_mem_intr.sv
// tb_io_mem_intr: directed stimulus with a read scoreboard; expected read
// data is queued at issue and compared by a monitor when the read appears.
module tb_io_mem_intr;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] STAT  = 32'h0000_03F8;
    localparam logic [31:0] TMR   = 32'h0000_03FC;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        io_cs   = 1'b0;
    logic        io_rd   = 1'b0;
    logic        io_wr   = 1'b0;
    logic [31:0] io_addr = 32'h0;
    logic [31:0] io_din  = 32'h0;
    logic [31:0] io_dout;
    logic        ext_evt = 1'b0;
    logic        int_ack = 1'b0;
    logic        intr;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    io_mem_intr #(.DEPTH(DEPTH), .STAT_ADDR(STAT), .TMR_ADDR(TMR)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .io_cs   (io_cs),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_din  (io_din),
        .io_dout (io_dout),
        .ext_evt (ext_evt),
        .int_ack (int_ack),
        .intr    (intr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Each bus task starts 1ns after a rising edge and returns 1ns after the next one.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0; io_addr = a; io_din = d;
        idle(1);
        io_cs = 1'b0; io_wr = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] e);
        exp_t x;
        x.name = name;
        x.val  = e;
        exp_q.push_back(x);
        io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0; io_addr = a;
        idle(1);
        io_cs = 1'b0; io_rd = 1'b0;
    endtask

    // Raise ext_evt for two cycles, then return 3 edges after the rise.
    task automatic pulse_evt();
        ext_evt = 1'b1;
        idle(2);
        ext_evt = 1'b0;
        idle(1);
    endtask

    // Monitor: compare every read the DUT presents against the queue head.
    always @(negedge sys_clk) begin
        if (!reset && io_cs && io_rd) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", io_dout, 32'hxxxx_xxxx);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check(x.name, io_dout, x.val);
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        #2;
        io_cs = 1'b1; io_rd = 1'b1; io_addr = 32'h10;
        #1;
        check("rst_intr", {31'b0, intr}, 32'h0);
        check("rst_dout", io_dout, 32'h0);
        io_cs = 1'b0; io_rd = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        idle(1);

        // Memory: aligned, low bits ignored, wrap on read and write.
        do_write(32'h10, 32'hDEAD_BEEF);
        do_read("mem_0x10", 32'h10, 32'hDEAD_BEEF);
        do_read("mem_0x12", 32'h12, 32'hDEAD_BEEF);
        do_read("mem_wrap", 32'h10 + DEPTH, 32'hDEAD_BEEF);
        do_write(32'h417, 32'h1234_5678);
        do_read("mem_wrap_wr", 32'h14, 32'h1234_5678);
        do_read("mem_keep", 32'h10, 32'hDEAD_BEEF);

        // External interrupt: intr exactly 4 edges after the rise.
        pulse_evt();
        check("ext_intr_e3", {31'b0, intr}, 32'h0);
        idle(1);
        check("ext_intr_e4", {31'b0, intr}, 32'h1);
        int_ack = 1'b1;
        idle(1);
        int_ack = 1'b0;
        check("ack_drop", {31'b0, intr}, 32'h0);
        do_read("stat_ext", STAT, 32'h1);
        do_write(STAT, 32'h1);
        check("w1c_intr", {31'b0, intr}, 32'h0);
        do_read("stat_clr", STAT, 32'h0);

        // Timer: period 5, two expiries set lost, then disable.
        do_write(TMR, 32'd5);
        do_read("tmr_rd", TMR, 32'd5);
        idle(3);
        check("tmr_e4", {31'b0, intr}, 32'h0);
        idle(1);
        check("tmr_e5", {31'b0, intr}, 32'h1);
        idle(5);
        do_read("stat_tmr2", STAT, 32'h6);
        do_write(TMR, 32'd0);
        do_write(STAT, 32'h7);
        check("tmr_clr_intr", {31'b0, intr}, 32'h0);
        idle(12);
        check("tmr_off_intr", {31'b0, intr}, 32'h0);
        do_read("stat_tmr_off", STAT, 32'h0);

        // Event set and W1C clear in the same cycle: set wins, no loss.
        pulse_evt();
        do_write(STAT, 32'h1);
        check("simul_intr", {31'b0, intr}, 32'h1);
        do_read("stat_simul", STAT, 32'h1);

        // Second event while pending marks lost.
        pulse_evt();
        idle(2);
        do_read("stat_lost", STAT, 32'h5);
        do_write(STAT, 32'h7);
        check("clr_all_intr", {31'b0, intr}, 32'h0);

        // Ack while idle is ignored: a later event still raises intr.
        int_ack = 1'b1;
        idle(1);
        int_ack = 1'b0;
        do_read("stat_idle_ack", STAT, 32'h0);
        do_write(TMR, 32'd100);
        pulse_evt();
        check("idle_ack_e3", {31'b0, intr}, 32'h0);
        idle(1);
        check("idle_ack_e4", {31'b0, intr}, 32'h1);

        // Asynchronous reset mid-cycle while intr=1.
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_intr", {31'b0, intr}, 32'h0);
        io_cs = 1'b1; io_rd = 1'b1; io_addr = TMR;
        #1;
        check("rst_hold_dout", io_dout, 32'h0);
        io_cs = 1'b0; io_rd = 1'b0;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        idle(1);
        do_read("stat_post_rst", STAT, 32'h0);
        do_read("tmr_post_rst", TMR, 32'h0);
        check("post_rst_intr", {31'b0, intr}, 32'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
